// File: rtl/alu_mul_sequencer_pkg.sv
// alu_seq_pkg: state encoding, ALU opcodes and flag indices shared by the ALU and its sequencers
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
endpackage

// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: request/result handshake plus the borrowed-ALU operand and result bus
interface alu_mul_sequencer_if #(parameter int BITS = 64);
  logic            Start;
  logic            Flush;
  logic [BITS-1:0] OpA;
  logic [BITS-1:0] OpB;
  logic            Busy;
  logic            Done;
  logic [BITS-1:0] Product;
  logic            Overflow;
  logic            AluOwn;
  logic [BITS-1:0] AluSrcA;
  logic [BITS-1:0] AluSrcB;
  logic [1:0]      AluControl;
  logic [BITS-1:0] AluResult;
  logic [3:0]      AluFlags;
  modport master (
    output Start, Flush, OpA, OpB, AluResult, AluFlags,
    input  Busy, Done, Product, Overflow, AluOwn, AluSrcA, AluSrcB, AluControl
  );
  modport slave (
    input  Start, Flush, OpA, OpB, AluResult, AluFlags,
    output Busy, Done, Product, Overflow, AluOwn, AluSrcA, AluSrcB, AluControl
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-add unsigned multiplier stepping on the shared external ALU.
// Defining MUL_EARLY_EXIT_EN ends the run as soon as the remaining multiplier is zero.
module alu_mul_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BITS = 64
) (
  input logic clk,
  input logic rst_n,
  alu_mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(BITS) + 1;
  state_e state_q, state_d;
  logic [BITS-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, product_q, product_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, overflow_q, overflow_d;
  logic [BITS-1:0] acc_step, mplier_step;
  logic ovf_step, last_step, unused_flags;
  assign unused_flags = ^{bus.AluFlags[FLAG_V], bus.AluFlags[FLAG_N], bus.AluFlags[FLAG_Z]};
  assign acc_step = mplier_q[0] ? bus.AluResult : acc_q;
  assign mplier_step = mplier_q >> 1;
  // a multiplicand bit shifted out while multiplier bits remain would contribute >= 2^BITS
  assign ovf_step = ovf_q | (mplier_q[0] & bus.AluFlags[FLAG_C]) | (mcand_q[BITS-1] & |mplier_step);
`ifdef MUL_EARLY_EXIT_EN
  assign last_step = (cnt_q == CW'(BITS - 1)) || (mplier_step == '0);
`else
  assign last_step = cnt_q == CW'(BITS - 1);
`endif
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    product_d = product_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (bus.Start) begin
        state_d = RUN;
        acc_d = '0;
        mcand_d = bus.OpA;
        mplier_d = bus.OpB;
        cnt_d = '0;
        ovf_d = 1'b0;
`ifdef MUL_EARLY_EXIT_EN
        if (bus.OpB == '0) begin
          state_d = DONE;
          product_d = '0;
          overflow_d = 1'b0;
        end
`endif
      end
      RUN: begin
        acc_d = acc_step;
        ovf_d = ovf_step;
        mcand_d = mcand_q << 1;
        mplier_d = mplier_step;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          state_d = DONE;
          product_d = acc_step;
          overflow_d = ovf_step;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.Flush && state_q != IDLE) begin
      state_d = IDLE;
      product_d = product_q;
      overflow_d = overflow_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      product_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      product_q <= product_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.Busy = state_q != IDLE;
  assign bus.Done = state_q == DONE;
  assign bus.AluOwn = state_q == RUN;
  assign bus.AluSrcA = acc_q;
  assign bus.AluSrcB = mcand_q;
  assign bus.AluControl = ALU_ADD;
  assign bus.Product = product_q;
  assign bus.Overflow = overflow_q;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed table, random operands against a 128-bit product model, flush/reset corners
module tb_alu_mul_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  alu_mul_sequencer_if #(.BITS(64)) bus ();
  alu_mul_sequencer #(.BITS(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // external ALU: adds while owned, drives junk otherwise so ignored results are exercised
  logic [64:0] sum;
  assign sum = {1'b0, bus.AluSrcA} + {1'b0, bus.AluSrcB};
  assign bus.AluResult = bus.AluOwn ? sum[63:0] : 64'hDEAD_BEEF_0BAD_F00D;
  assign bus.AluFlags = bus.AluOwn ? {1'b0, sum[64], sum[63], sum[63:0] == 64'd0} : 4'hF;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
    logic        o;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int exp_lat(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
    if (b == 64'd0) return 1;
    for (int i = 63; i >= 0; i--) if (b[i]) return i + 2;
`endif
    return 65;
  endfunction
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.OpA = a;
    bus.OpB = b;
    @(posedge clk);
    #1 bus.Start = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int own);
    lat = -1;
    own = 0;
    for (int n = 0; n < 200; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      own += int'(bus.AluOwn);
      if (bus.Done) begin
        lat = n + 1;
        return;
      end
    end
  endtask
  task automatic run_check(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] p, input logic o);
    int lat, own;
    start_op(a, b);
    wait_done(lat, own);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat(b)));
    chk({name, " alu_own"}, 64'(own), 64'(exp_lat(b) - 1));
    chk({name, " product"}, bus.Product, p);
    chk({name, " overflow"}, 64'(bus.Overflow), 64'(o));
    @(posedge clk);
    #1;
    chk({name, " done_pulse"}, 64'({bus.Done, bus.Busy}), 64'd0);
  endtask
  task automatic chk_reset_outputs(input string name);
    chk({name, " flags"}, 64'({bus.Busy, bus.Done, bus.AluOwn, bus.Overflow}), 64'd0);
    chk({name, " product"}, bus.Product, 64'd0);
    chk({name, " srcs"}, 64'(bus.AluSrcA | bus.AluSrcB), 64'd0);
    chk({name, " ctrl"}, 64'(bus.AluControl), 64'd0);
  endtask
  initial begin
    logic [127:0] full;
    logic [63:0] a, b;
    int lat, own, done_seen;
    vecs[0] = '{64'd3, 64'd5, 64'd15, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000, 1'b1};
    vecs[4] = '{64'd7, 64'd4, 64'd28, 1'b0};
    vecs[5] = '{64'd5, 64'd0, 64'd0, 1'b0};
    vecs[6] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
    vecs[7] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
    vecs[8] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1};
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    bus.OpA = '0;
    bus.OpB = '0;
    #1 chk_reset_outputs("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o);
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      full = {64'd0, a} * {64'd0, b};
      run_check($sformatf("rand%0d", i), a, b, full[63:0], |full[127:64]);
    end
    start_op(64'd3, 64'd5);
    repeat (5) begin
      @(negedge clk);
      bus.Start = 1'b1;
      bus.OpA = 64'd99;
      bus.OpB = 64'd77;
    end
    @(negedge clk) bus.Start = 1'b0;
    wait_done(lat, own);
    chk("start_ignored done", 64'(lat > 0), 64'd1);
    chk("start_ignored product", bus.Product, 64'd15);
    @(posedge clk);
    start_op(64'd11, 64'hFFFF_0000_0000_0001);
    repeat (9) @(posedge clk);
    @(negedge clk) bus.Flush = 1'b1;
    @(posedge clk);
    #1 bus.Flush = 1'b0;
    chk("flush state", 64'({bus.Busy, bus.AluOwn, bus.Done}), 64'd0);
    chk("flush product kept", bus.Product, 64'd15);
    done_seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1 done_seen += int'(bus.Done);
    end
    chk("flush no done", 64'(done_seen), 64'd0);
    chk("flush product still", bus.Product, 64'd15);
    start_op(64'd13, 64'hFFFF_FFFF_0000_0003);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("reset_midrun");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("reset release idle", 64'({bus.Busy, bus.Done}), 64'd0);
    run_check("after_reset", 64'd6, 64'd9, 64'd54, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
